// File: rtl/muxn_rr_reg.sv
// N-to-1 round-robin arbitrated mux with a one-entry registered output and valid/ready handshakes.
// Optional packet locking is enabled by defining MUXN_RR_LOCK_EN (adds the in_last port).
module muxn_rr_reg #(
  parameter int WIDTH = 64,
  parameter int N     = 4,
  parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N-1:0]              in_valid,
  input  logic [N-1:0][WIDTH-1:0]   in_data,
`ifdef MUXN_RR_LOCK_EN
  input  logic [N-1:0]              in_last,
`endif
  output logic [N-1:0]              in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_chan_q,  out_chan_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;
  logic [SELW-1:0]  ptr_nxt;
  logic             load;
  logic             gnt_vld;
  logic [SELW-1:0]  gnt_idx;
`ifdef MUXN_RR_LOCK_EN
  logic             lock_q, lock_d;
  logic [SELW-1:0]  lock_chan_q, lock_chan_d;
`endif

  assign load = !out_valid_q || out_ready;

  // Grant search starts at ptr and wraps explicitly, so N need not be a power of 2.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
`ifdef MUXN_RR_LOCK_EN
    if (lock_q) begin
      gnt_vld = in_valid[lock_chan_q];
      gnt_idx = lock_chan_q;
    end else begin
`endif
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= N) idx = idx - N;
        if (!gnt_vld && in_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(idx);
        end
      end
`ifdef MUXN_RR_LOCK_EN
    end
`endif
  end

  always_comb begin
    in_ready = '0;
    if (load && gnt_vld && !reset) in_ready[gnt_idx] = 1'b1;
  end

  assign ptr_nxt = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
`ifdef MUXN_RR_LOCK_EN
    lock_d      = lock_q;
    lock_chan_d = lock_chan_q;
`endif
    if (load) begin
      if (gnt_vld) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data[gnt_idx];
        out_chan_d  = gnt_idx;
`ifdef MUXN_RR_LOCK_EN
        // The pointer only advances on the word that closes a packet.
        if (in_last[gnt_idx]) begin
          ptr_d  = ptr_nxt;
          lock_d = 1'b0;
        end else begin
          lock_d      = 1'b1;
          lock_chan_d = gnt_idx;
        end
`else
        ptr_d = ptr_nxt;
`endif
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
`ifdef MUXN_RR_LOCK_EN
      lock_q      <= 1'b0;
      lock_chan_q <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
`ifdef MUXN_RR_LOCK_EN
      lock_q      <= lock_d;
      lock_chan_q <= lock_chan_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule
